// File: rtl/seed_pkg.sv
// Shared definitions for the seed-selection control unit: state codes,
// state width and the default length of the selection window.
package seed_pkg;

    localparam int STATE_W     = 3;
    localparam int TIMEOUT_DEF = 1000;

    typedef enum logic [STATE_W-1:0] {
        ST_INICIAL  = 3'd0,
        ST_PREPARA  = 3'd1,
        ST_ESCOLHE  = 3'd2,
        ST_REGISTRA = 3'd3,
        ST_PRONTO   = 3'd4
    } estado_t;

endpackage

// File: rtl/unidade_controle_seed_temporizador.sv
// Saturating selection-window timer with synchronous clear and enable.
// Latency: count updates on the edge after enable; fim is decoded from the count register.
module temporizador_seed #(
    parameter  int TIMEOUT = seed_pkg::TIMEOUT_DEF,
    localparam int TW      = $clog2(TIMEOUT)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [TW-1:0] VALOR_MAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] valor_q;
    logic [TW-1:0] valor_d;

    // Holds at VALOR_MAX so a late exit from the window cannot wrap back to zero.
    always_comb begin
        valor_d = valor_q;
        if (zera) begin
            valor_d = '0;
        end else if (conta && (valor_q != VALOR_MAX)) begin
            valor_d = valor_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign fim = (valor_q == VALOR_MAX);

endmodule

// File: rtl/unidade_controle_seed.sv
// Game-start seed selection sequencer: clears the seed counter, opens the selection window, loads the seed.
// Latency: one edge per state step; all outputs come from registers only, no input-to-output paths.
module unidade_controle_seed
    import seed_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               confirmar,
    input  logic               reiniciar,
    output logic               zera_CS,
    output logic               e_seed_reg,
    output logic               escolhendo,
    output logic               seed_pronta,
    output logic               timeout,
    output logic [STATE_W-1:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    logic    timeout_q;
    logic    timeout_d;
    logic    iniciar_ant_q;
    logic    confirmar_ant_q;
    logic    ini_borda;
    logic    conf_borda;
    logic    tmr_zera;
    logic    tmr_conta;
    logic    tmr_fim;

    // Previous samples reset high so a level already asserted at reset release is not an edge.
    assign ini_borda  = iniciar   & ~iniciar_ant_q;
    assign conf_borda = confirmar & ~confirmar_ant_q;

    temporizador_seed #(
        .TIMEOUT (TIMEOUT)
    ) u_temporizador (
        .clock (clock),
        .reset (reset),
        .zera  (tmr_zera),
        .conta (tmr_conta),
        .fim   (tmr_fim)
    );

    always_comb begin
        estado_d  = estado_q;
        timeout_d = timeout_q;
        tmr_zera  = 1'b0;
        tmr_conta = 1'b0;
        case (estado_q)
            ST_INICIAL: begin
                if (ini_borda) begin
                    estado_d = ST_PREPARA;
                end
            end
            ST_PREPARA: begin
                tmr_zera  = 1'b1;
                timeout_d = 1'b0;
                estado_d  = ST_ESCOLHE;
            end
            ST_ESCOLHE: begin
                tmr_conta = 1'b1;
                if (reiniciar) begin
                    estado_d = ST_PREPARA;
                end else if (conf_borda) begin
                    estado_d = ST_REGISTRA;
                end else if (tmr_fim) begin
                    estado_d  = ST_REGISTRA;
                    timeout_d = 1'b1;
                end
            end
            ST_REGISTRA: begin
                estado_d = ST_PRONTO;
            end
            ST_PRONTO: begin
                if (reiniciar) begin
                    estado_d = ST_PREPARA;
                end
            end
            default: begin
                estado_d  = ST_INICIAL;
                timeout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q        <= ST_INICIAL;
            timeout_q       <= 1'b0;
            iniciar_ant_q   <= 1'b1;
            confirmar_ant_q <= 1'b1;
        end else begin
            estado_q        <= estado_d;
            timeout_q       <= timeout_d;
            iniciar_ant_q   <= iniciar;
            confirmar_ant_q <= confirmar;
        end
    end

    assign zera_CS     = (estado_q == ST_PREPARA);
    assign e_seed_reg  = (estado_q == ST_REGISTRA);
    assign escolhendo  = (estado_q == ST_ESCOLHE);
    assign seed_pronta = (estado_q == ST_PRONTO);
    assign timeout     = timeout_q;
    assign db_estado   = estado_q;

endmodule

// File: tb/tb_unidade_controle_seed.sv
// Bench for unidade_controle_seed with an 8-cycle selection window.
// A behavioural model tracks phase and window age; directed scenarios add literal expectations.
module tb_unidade_controle_seed;

    localparam int T = 8;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       confirmar;
    logic       reiniciar;
    logic       zera_CS;
    logic       e_seed_reg;
    logic       escolhendo;
    logic       seed_pronta;
    logic       timeout;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;
    int ecnt   = 0;

    // Model: phase 0 idle, 1 prepare, 2 window, 3 load, 4 ready
    int m_st    = 0;
    int m_to    = 0;
    int m_pi    = 1;
    int m_pc    = 1;
    int m_entry = 0;
    int cyc     = 0;
    bit ei;
    bit ec;

    unidade_controle_seed #(
        .TIMEOUT (T)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .confirmar   (confirmar),
        .reiniciar   (reiniciar),
        .zera_CS     (zera_CS),
        .e_seed_reg  (e_seed_reg),
        .escolhendo  (escolhendo),
        .seed_pronta (seed_pronta),
        .timeout     (timeout),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // The window closes by itself once it has been open for T cycles.
    always @(posedge clock) begin
        if (reset) begin
            m_st = 0;
            m_to = 0;
            m_pi = 1;
            m_pc = 1;
        end else begin
            ei = iniciar && (m_pi == 0);
            ec = confirmar && (m_pc == 0);
            case (m_st)
                0: if (ei) m_st = 1;
                1: begin
                    m_st    = 2;
                    m_to    = 0;
                    m_entry = cyc;
                end
                2: begin
                    if (reiniciar) m_st = 1;
                    else if (ec) m_st = 3;
                    else if (cyc - m_entry >= T) begin
                        m_st = 3;
                        m_to = 1;
                    end
                end
                3: m_st = 4;
                4: if (reiniciar) m_st = 1;
                default: m_st = 0;
            endcase
            m_pi = int'(iniciar);
            m_pc = int'(confirmar);
        end
        cyc++;
    end

    always @(negedge clock) begin
        if (e_seed_reg) ecnt++;
        if (cmp_en) begin
            chk("db_estado",   int'(db_estado),   m_st);
            chk("zera_CS",     int'(zera_CS),     int'(m_st == 1));
            chk("e_seed_reg",  int'(e_seed_reg),  int'(m_st == 3));
            chk("escolhendo",  int'(escolhendo),  int'(m_st == 2));
            chk("seed_pronta", int'(seed_pronta), int'(m_st == 4));
            chk("timeout",     int'(timeout),     m_to);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int e0;
        reset     = 1'b1;
        iniciar   = 1'b1;
        confirmar = 1'b0;
        reiniciar = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_db", int'(db_estado), 0);
        chk("rst_timeout", int'(timeout), 0);

        // Scenario 1: iniciar high through reset release is not an edge
        reset = 1'b0;
        repeat (3) tick();
        chk("noedge_zera", int'(zera_CS), 0);
        chk("noedge_db", int'(db_estado), 0);
        iniciar = 1'b0;
        tick();
        iniciar = 1'b1;
        tick();
        chk("ini_zera", int'(zera_CS), 1);
        chk("ini_db1", int'(db_estado), 1);
        tick();
        chk("ini_zera_off", int'(zera_CS), 0);
        chk("ini_db2", int'(db_estado), 2);

        // Scenario 2: confirm three cycles into the window
        repeat (3) tick();
        confirmar = 1'b1;
        e0 = ecnt;
        tick();
        chk("conf_e", int'(e_seed_reg), 1);
        tick();
        chk("conf_db", int'(db_estado), 4);
        chk("conf_ready", int'(seed_pronta), 1);
        chk("conf_to", int'(timeout), 0);
        chk("conf_pulses", ecnt - e0, 1);
        chk("model_ready", m_st, 4);
        confirmar = 1'b0;

        // Scenario 3: no input, auto-load after T cycles
        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
        tick();
        n = 0;
        while (db_estado != 3'd3 && n < 20) begin
            tick();
            n++;
        end
        chk("to_edges", n, 8);
        chk("to_e", int'(e_seed_reg), 1);
        tick();
        chk("to_flag", int'(timeout), 1);
        chk("to_ready", int'(seed_pronta), 1);
        chk("model_to", m_to, 1);

        // Scenario 5 then 4a: restart from ready, confirm when timer reads T-1
        reiniciar = 1'b1;
        tick();
        chk("rein_zera", int'(zera_CS), 1);
        chk("rein_db", int'(db_estado), 1);
        reiniciar = 1'b0;
        tick();
        chk("rein_to_clr", int'(timeout), 0);
        chk("rein_zera_off", int'(zera_CS), 0);
        repeat (7) tick();
        chk("late_pre_db", int'(db_estado), 2);
        confirmar = 1'b1;
        tick();
        chk("late_conf_e", int'(e_seed_reg), 1);
        chk("late_conf_to", int'(timeout), 0);
        confirmar = 1'b0;
        tick();
        chk("late_conf_rdy", int'(seed_pronta), 1);
        chk("late_conf_to2", int'(timeout), 0);

        // Scenario 4b: reiniciar beats a simultaneous confirm edge
        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
        tick();
        repeat (2) tick();
        reiniciar = 1'b1;
        confirmar = 1'b1;
        e0 = ecnt;
        tick();
        chk("both_db", int'(db_estado), 1);
        chk("both_zera", int'(zera_CS), 1);
        reiniciar = 1'b0;
        confirmar = 1'b0;
        tick();
        chk("both_db2", int'(db_estado), 2);
        chk("both_nopulse", ecnt - e0, 0);

        // Scenario 6: reset lands during the load cycle
        tick();
        confirmar = 1'b1;
        e0 = ecnt;
        tick();
        chk("r6_e", int'(e_seed_reg), 1);
        reset = 1'b1;
        tick();
        chk("r6_db", int'(db_estado), 0);
        chk("r6_e_off", int'(e_seed_reg), 0);
        chk("r6_zera", int'(zera_CS), 0);
        chk("r6_esc", int'(escolhendo), 0);
        chk("r6_ready", int'(seed_pronta), 0);
        chk("r6_to", int'(timeout), 0);
        reset     = 1'b0;
        confirmar = 1'b0;
        repeat (3) tick();
        chk("r6_pulses", ecnt - e0, 1);
        chk("r6_idle", int'(db_estado), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
